pc_reg: RTL and testbench
=========================

// Module: pc_reg
// PURPOSE
//   Program-counter register for the single-cycle MIPS datapath.
//   Holds the address of the instruction being fetched and loads the
//   next-PC value every rising clock edge.
//   Feeds instruction memory and the PC+4/branch/jump adders.
//   pc_in is supplied by the next-PC mux.
// PARAMETERS
//   WIDTH        32            address width in bits
//   RESET_VALUE  32'h0000_0000 value loaded when reset is asserted
// PORTS
//   clk      in   1      system clock, rising-edge active
//   reset    in   1      synchronous, active-high reset
//   pc_in    in   WIDTH  next-PC value from the next-PC mux
//   pc_out   out  WIDTH  current PC, registered
// BEHAVIOUR
//   - Clocking: one clock (clk). Reset is synchronous and active-high.
//   - Reset: at a rising edge with reset=1, pc_out <= RESET_VALUE.
//     pc_in is ignored on that edge.
//   - Load: at a rising edge with reset=0, pc_out <= pc_in.
//     Every edge loads; there is no enable and no stall.
//   - Latency:
//     - pc_out updates one clk edge after pc_in is sampled.
//     - It is stable for the whole following cycle.
//     - There is no combinational path from pc_in or reset to pc_out.
//   - Reset is sampled only at rising edges.
//     - A reset pulse between edges has no effect.
//     - Deassertion takes effect at the next edge.
//   - Before the first rising edge, pc_out is uninitialised (X in sim).
//     There is no asynchronous clear.
//   - Width rules:
//     - pc_in is stored verbatim: no alignment masking, no +4 inside.
//     - Wider drivers are truncated to the low WIDTH bits by the
//       connecting context.
//   - Reset mid-run:
//     - The PC returns to RESET_VALUE at the edge.
//     - It loads pc_in normally at the first edge with reset=0.
//   - Boundary: pc_in = all-ones is held as-is. No wrap or overflow
//     logic lives in this block.
// STRUCTURE
//   - RESET_VALUE default and WIDTH belong in the shared cpu package.
//     The package holds ADDR_W=32 and the PC_RESET vector.
//   - Single always block, flip-flop bank only. No sub-module.
//   - Optional simulation-only assertion: after a reset edge,
//     pc_out == RESET_VALUE.
// TESTING
//   - Free-running load, reset=0, pc_in=32'h0003_FFF2:
//     first edge -> pc_out=32'h0003_FFF2.
//   - Reset dominates, reset=1, pc_in=32'h0803_FFF2:
//     next edge -> pc_out=32'h0000_0000, not 0803_FFF2.
//   - Release, reset=0, pc_in=32'hF003_FFF2:
//     next edge -> pc_out=32'hF003_FFF2.
//   - Registered only: change pc_in mid-cycle (negedge) 32'h0000_0004
//     -> 32'h0000_0008. pc_out holds its prior value until the next
//     posedge, then becomes 32'h0000_0008.
//   - Sync reset: pulse reset high between posedges only, pc_in=32'h10
//     -> pc_out is not cleared; next edge pc_out=32'h10.
//   - Extremes:
//     - pc_in=32'hFFFF_FFFF then 32'h0 -> pc_out follows exactly,
//       edge by edge.
//     - With RESET_VALUE=32'h0040_0000, a reset edge -> pc_out=32'h0040_0000.

Source files
------------

// File: rtl/pc_reg_pkg.sv
// Shared CPU constants: address width and the PC reset vector.
package pc_reg_pkg;

  localparam int unsigned ADDR_W = 32;

  localparam logic [ADDR_W-1:0] PC_RESET = 32'h0000_0000;

endpackage

// File: rtl/pc_reg.sv
// Program-counter register: loads the next-PC every rising edge, sync reset to RESET_VALUE.
// Latency 1 edge, registered output; no enable, no stall, never backpressures.
module pc_reg
  import pc_reg_pkg::*;
#(
  parameter int unsigned        WIDTH       = ADDR_W,
  parameter logic [WIDTH-1:0]   RESET_VALUE = PC_RESET[WIDTH-1:0]
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pc_in,
  output logic [WIDTH-1:0] pc_out
);

  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] pc_q;

  // pc_in is taken verbatim: alignment and increment live in the next-PC mux.
  always_comb begin
    pc_d = pc_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_VALUE;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_out = pc_q;

  a_reset_value: assert property (@(posedge clk) reset |=> (pc_out == RESET_VALUE));

endmodule

// File: tb/tb_pc_reg.sv
// Self-checking bench for pc_reg: vector table plus mid-cycle sequences, scoreboard queue.
module tb_pc_reg;

  logic        clk;
  logic        reset;
  logic [31:0] pc_in;
  logic [31:0] pc_out0;
  logic [31:0] pc_out1;

  int checks = 0;
  int errors = 0;

  pc_reg dut0 (
    .clk    (clk),
    .reset  (reset),
    .pc_in  (pc_in),
    .pc_out (pc_out0)
  );

  pc_reg #(.WIDTH(32), .RESET_VALUE(32'h0040_0000)) dut1 (
    .clk    (clk),
    .reset  (reset),
    .pc_in  (pc_in),
    .pc_out (pc_out1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] din;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;

  typedef struct {
    logic [31:0] e0;
    logic [31:0] e1;
  } exp_t;

  vec_t vecs [10];
  exp_t sbq [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pop_check(input string name);
    exp_t e;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got %h expected an entry", name, pc_out0);
    end else begin
      e = sbq.pop_front();
      check(name, pc_out0, e.e0);
      check({name, "_rv"}, pc_out1, e.e1);
    end
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'h1234_5678, 32'h0000_0000, 32'h0040_0000};
    vecs[1] = '{1'b0, 32'h0003_FFF2, 32'h0003_FFF2, 32'h0003_FFF2};
    vecs[2] = '{1'b1, 32'h0803_FFF2, 32'h0000_0000, 32'h0040_0000};
    vecs[3] = '{1'b0, 32'hF003_FFF2, 32'hF003_FFF2, 32'hF003_FFF2};
    vecs[4] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[5] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    vecs[6] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[7] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0040_0000};
    vecs[8] = '{1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[9] = '{1'b0, 32'h0000_0003, 32'h0000_0003, 32'h0000_0003};

    reset = 1'b1;
    pc_in = 32'h0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      reset = vecs[i].rst;
      pc_in = vecs[i].din;
      sbq.push_back('{vecs[i].e0, vecs[i].e1});
      @(posedge clk);
      #1;
      pop_check($sformatf("vec%0d", i));
    end

    // pc_in changes mid-cycle; output must hold until the next rising edge.
    reset = 1'b0;
    pc_in = 32'h0000_0004;
    @(negedge clk);
    pc_in = 32'h0000_0008;
    #1;
    check("hold_mid_cycle", pc_out0, 32'h0000_0003);
    sbq.push_back('{32'h0000_0008, 32'h0000_0008});
    @(posedge clk);
    #1;
    pop_check("load_after_change");

    // Reset pulse strictly between edges must not clear the PC.
    pc_in = 32'h0000_0010;
    #1 reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("no_async_clr", pc_out0, 32'h0000_0008);
    check("no_async_clr_rv", pc_out1, 32'h0000_0008);
    sbq.push_back('{32'h0000_0010, 32'h0000_0010});
    @(posedge clk);
    #1;
    pop_check("load_after_glitch");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
